// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: holds the clock low to inhibit, issues a start bit,
// then shifts one byte plus odd parity on device falling edges and samples the ack bit.
module ps2_host_tx #(
    parameter int CLK_HZ     = 25000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic [1:0] status
);
    localparam int     US_CYC      = CLK_HZ / 1000000;
    localparam int     INHIBIT_CYC = US_CYC * INHIBIT_US;
    localparam longint TMO_L       = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 1000;
    localparam int     TIMEOUT_CYC = int'(TMO_L);
    localparam int     CNT_MAX     = (INHIBIT_CYC > US_CYC) ? INHIBIT_CYC : US_CYC;
    localparam int     CNT_W       = $clog2(CNT_MAX + 1);
    localparam int     TMO_W       = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_clk_s1;
    logic               r_clk_s2;
    logic               r_clk_prev;
    logic               r_dat_s1;
    logic               r_dat_s2;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic [3:0]         r_bitn;
    logic [7:0]         r_data;
    logic               r_dat_drv;
    logic               r_nack;

    logic               w_fall;
    logic               w_inh_end;
    logic               w_start_end;
    logic               w_active;
    logic               w_tmo;
    logic               w_done_ok;

    assign w_fall      = r_clk_prev & ~r_clk_s2;
    assign w_inh_end   = (r_state == S_INHIBIT) && (r_cnt == CNT_W'(INHIBIT_CYC - 1));
    assign w_start_end = (r_state == S_START) && (r_cnt == CNT_W'(US_CYC - 1));
    assign w_active    = (r_state == S_START) || (r_state == S_BITS) ||
                         (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_tmo       = w_active && (r_tmo == TMO_W'(TIMEOUT_CYC));
    assign w_done_ok   = (r_state == S_WAIT_IDLE) && r_clk_s2 && r_dat_s2;

    // Outputs decode straight from state so an async reset releases the pins at once.
    assign busy       = (r_state != S_IDLE);
    assign rx_inhibit = busy;
    assign tx_ready   = ~busy;
    assign done       = w_done_ok | w_tmo;
    assign status     = w_done_ok ? {1'b0, r_nack} : (w_tmo ? 2'b10 : 2'b00);
    assign ps2_clk_oe = ((r_state == S_INHIBIT) || (r_state == S_START)) && !w_tmo;
    assign ps2_dat_oe = ((r_state == S_START) || ((r_state == S_BITS) && r_dat_drv)) && !w_tmo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (tx_valid) w_next = S_INHIBIT;
            S_INHIBIT:   if (w_inh_end) w_next = S_START;
            S_START:     if (w_start_end) w_next = S_BITS;
            S_BITS:      if (w_fall && (r_bitn == 4'd9)) w_next = S_ACK;
            S_ACK:       if (w_fall) w_next = S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_done_ok) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (w_tmo) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_bitn     <= '0;
            r_data     <= '0;
            r_dat_drv  <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_i;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_dat_i;
            r_dat_s2   <= r_dat_s1;
            r_state    <= w_next;

            if ((r_state == S_IDLE) && tx_valid) r_data <= tx_data;

            case (r_state)
                S_INHIBIT: r_cnt <= w_inh_end ? '0 : r_cnt + 1'b1;
                S_START:   r_cnt <= r_cnt + 1'b1;
                default:   r_cnt <= '0;
            endcase

            // Timeout window opens on START entry and runs until completion.
            if (w_active && !w_tmo) r_tmo <= r_tmo + 1'b1;
            else                    r_tmo <= '0;

            if (w_start_end) begin
                r_dat_drv <= 1'b1;
                r_bitn    <= '0;
            end else if ((r_state == S_BITS) && w_fall) begin
                r_bitn <= r_bitn + 1'b1;
                if (r_bitn < 4'd8)       r_dat_drv <= ~r_data[r_bitn[2:0]];
                else if (r_bitn == 4'd8) r_dat_drv <= ^r_data;
                else                     r_dat_drv <= 1'b0;
            end

            if ((r_state == S_ACK) && w_fall) r_nack <= r_dat_s2;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector bus and a simple PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH_CYC = 2500;   // 25 cycles/us * 100 us
    localparam int US_CYC  = 25;
    localparam int TMO_CYC = 25000;  // 1 ms at 25 MHz
    localparam int HALF    = 40;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic [1:0] status;
    logic       dev_clk_low;
    logic       dev_dat_low;

    int n_assert;
    int n_fail;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ    (25000000),
        .INHIBIT_US(100),
        .TIMEOUT_MS(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .rx_inhibit(rx_inhibit),
        .done      (done),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_bits_entry(input string tag, output int inh, output int st);
        inh = 0;
        st  = 0;
        for (int g = 0; g < 5000; g++) begin
            if (!ps2_clk_oe && ps2_dat_oe) break;
            if (ps2_clk_oe && !ps2_dat_oe) inh++;
            else if (ps2_clk_oe && ps2_dat_oe) st++;
            @(negedge clk);
        end
        chk({tag, "/start_bit"}, {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'h1);
    endtask

    task automatic dev_clock(input int nedges, input bit ack, output logic [9:0] bits);
        bits = '0;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_dat_i;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) dev_dat_low = 1'b1;
            if (k < nedges) repeat (HALF) @(negedge clk);
        end
        if (ack && nedges == 11) begin
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int g = 0; g < 2000; g++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({tag, "/done_seen"}, done, 1);
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack, input logic [9:0] exp_bits,
                        input logic [1:0] exp_st, input string tag);
        int inh, st;
        logic [9:0] bits;
        send(d);
        chk({tag, "/busy_after_accept"}, {busy, rx_inhibit}, 2'b11);
        wait_bits_entry(tag, inh, st);
        chk({tag, "/inhibit_cycles"}, inh, INH_CYC);
        chk({tag, "/start_cycles"}, st, US_CYC);
        dev_clock(11, ack, bits);
        chk({tag, "/line_bits"}, bits, exp_bits);
        wait_done(tag);
        chk({tag, "/status"}, status, exp_st);
        chk({tag, "/done_busy_ready"}, {busy, tx_ready, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
        @(negedge clk);
        chk({tag, "/after_done"}, {done, busy, tx_ready}, 3'b001);
    endtask

    initial begin
        int inh, st, cnt;
        logic [9:0] bits;
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/outputs", {ps2_clk_oe, ps2_dat_oe, busy, done, status}, 6'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset/ready_first_edge", tx_ready, 1);

        // Line values LSB first, then parity, then stop.
        xfer(8'hF4, 1'b1, 10'b1_0_11110100, 2'b00, "f4_ack");
        xfer(8'hFF, 1'b1, 10'b1_1_11111111, 2'b00, "ff_ack");
        xfer(8'h00, 1'b0, 10'b1_1_00000000, 2'b01, "00_noack");

        // Device never clocks: timeout measured from the first START cycle.
        send(8'h5A);
        for (int g = 0; g < 5000; g++) begin
            if (ps2_clk_oe && ps2_dat_oe) break;
            @(negedge clk);
        end
        chk("tmo/start_seen", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
        cnt = 0;
        while (!done && cnt < TMO_CYC + 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("tmo/cycles", cnt, TMO_CYC);
        chk("tmo/status", status, 2'b10);
        chk("tmo/pins_released", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b001);
        @(negedge clk);
        chk("tmo/idle_after", {done, busy, tx_ready}, 3'b001);

        // Reset after five device edges.
        send(8'hF4);
        wait_bits_entry("rst_mid", inh, st);
        dev_clock(5, 1'b0, bits);
        chk("rst_mid/bits_so_far", bits[4:0], 5'b10100);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid/async_release", {ps2_clk_oe, ps2_dat_oe, busy, done, status, tx_ready}, 7'b0000001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid/ready_after", tx_ready, 1);
        xfer(8'hF4, 1'b1, 10'b1_0_11110100, 2'b00, "f4_after_rst");

        // Request held high with a changing byte during the transfer.
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hAA;
        wait_bits_entry("hold", inh, st);
        chk("hold/inhibit_cycles", inh, INH_CYC);
        dev_clock(11, 1'b1, bits);
        chk("hold/line_bits", bits, 10'b1_0_11110100);
        wait_done("hold");
        chk("hold/status", status, 2'b00);
        chk("hold/no_accept_on_done", tx_ready, 0);
        @(negedge clk);
        chk("hold/ready_after_done", {done, tx_ready}, 2'b01);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("hold/aa_accepted", busy, 1);
        wait_bits_entry("aa", inh, st);
        chk("aa/inhibit_cycles", inh, INH_CYC);
        dev_clock(11, 1'b1, bits);
        chk("aa/line_bits", bits, 10'b1_1_10101010);
        wait_done("aa");
        chk("aa/status", status, 2'b00);
        @(negedge clk);
        chk("aa/idle_after", {busy, tx_ready}, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
